// File: rtl/aes_pkg.sv
// AES shared types, constant tables and GF(2^8) helpers for the iterative cipher.
package aes_pkg;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] word_t;
   // [column][row]; index [0][0] maps to bits 127:120 (byte 0, column-major)
   typedef logic [0:3][0:3][7:0] state_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_KEY_EXP = 2'd1,
      S_ROUND   = 2'd2,
      S_DONE    = 2'd3
   } aes_fsm_e;

   localparam byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Rcon[0] is unused; only 1..10 are reachable
   localparam byte_t RCON [11] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic int unsigned aes_nr(input int unsigned nk);
      return nk + 6;
   endfunction

   function automatic int unsigned aes_nw(input int unsigned nk);
      return 4 * (nk + 7);
   endfunction

   function automatic byte_t sbox(input byte_t b);
      return SBOX[b];
   endfunction

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column byte 0 (row 0) sits in bits 31:24
   function automatic word_t mix_column(input word_t col);
      byte_t a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
   import aes_pkg::*;
(
   input  state_t state_i,
   input  state_t round_key_i,
   input  logic   is_last_i,
   output state_t state_o
);

   state_t sr;
   state_t mc;

   // Byte substitution fused with the row rotation, then column mixing
   always_comb begin
      sr = '0;
      mc = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[2'(c)][2'(r)] = sbox(state_i[2'(c + r)][2'(r)]);
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[2'(c)] = mix_column(sr[2'(c)]);
      end
      state_o = (is_last_i ? sr : mc) ^ round_key_i;
   end

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128/192/256 encryptor: one round per clock, key expanded once into a register file.
module aes_iter_cipher
   import aes_pkg::*;
#(
   parameter int unsigned NK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NK*32-1:0] key_in,
   input  logic             key_load,
   output logic             key_ready,
   output logic             key_ok,
   input  logic [127:0]     data_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [127:0]     data_out,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned NR = aes_nr(NK);
   localparam int unsigned NW = aes_nw(NK);
   localparam int unsigned IW = $clog2(NW);
   localparam int unsigned RW = $clog2(NR + 1);

   aes_fsm_e     fsm_q;
   word_t        w_q [NW];
   logic [IW-1:0] i_q;
   logic [2:0]   kmod_q;     // i mod NK
   logic [3:0]   kdiv_q;     // i / NK, selects Rcon
   logic [RW-1:0] r_q;
   state_t       st_q;
   logic         key_ok_q;
   logic         key_ready_q;
   logic         out_valid_q;

   word_t        temp_w;
   word_t        prev_w;
   word_t        sub_in;
   word_t        sub_w;
   word_t        tf_w;
   word_t        new_w_d;
   logic [IW-1:0] rk_idx;
   state_t       rk_d;
   state_t       round_d;
   logic         is_last;

   // Next schedule word from w[i-1] and w[i-NK]
   always_comb begin
      temp_w = w_q[i_q - IW'(1)];
      prev_w = w_q[i_q - IW'(NK)];
      sub_in = (kmod_q == 3'd0) ? {temp_w[23:0], temp_w[31:24]} : temp_w;
      sub_w  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
      if (kmod_q == 3'd0) begin
         tf_w = sub_w ^ {RCON[kdiv_q], 24'h000000};
      end else if (NK == 8 && kmod_q == 3'd4) begin
         tf_w = sub_w;
      end else begin
         tf_w = temp_w;
      end
      new_w_d = prev_w ^ tf_w;
   end

   // Round key select: rk0 for the initial whitening in IDLE, rk[r] while iterating
   always_comb begin
      rk_idx  = (fsm_q == S_ROUND) ? IW'({r_q, 2'b00}) : '0;
      rk_d    = {w_q[rk_idx], w_q[rk_idx + IW'(1)], w_q[rk_idx + IW'(2)], w_q[rk_idx + IW'(3)]};
      is_last = (r_q == RW'(NR));
   end

   aes_round u_round (
      .state_i    (st_q),
      .round_key_i(rk_d),
      .is_last_i  (is_last),
      .state_o    (round_d)
   );

   // Control FSM, key schedule store and cipher state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= S_IDLE;
         i_q         <= '0;
         kmod_q      <= '0;
         kdiv_q      <= '0;
         r_q         <= '0;
         st_q        <= '0;
         key_ok_q    <= 1'b0;
         key_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
         for (int k = 0; k < NW; k++) begin
            w_q[IW'(k)] <= '0;
         end
      end else begin
         case (fsm_q)
            S_IDLE: begin
               if (key_load) begin
                  for (int k = 0; k < NK; k++) begin
                     w_q[IW'(k)] <= key_in[(NK - 1 - k) * 32 +: 32];
                  end
                  i_q         <= IW'(NK);
                  kmod_q      <= 3'd0;
                  kdiv_q      <= 4'd1;
                  key_ok_q    <= 1'b0;
                  key_ready_q <= 1'b0;
                  fsm_q       <= S_KEY_EXP;
               end else if (in_valid && key_ok_q) begin
                  st_q        <= data_in ^ rk_d;
                  r_q         <= RW'(1);
                  key_ready_q <= 1'b0;
                  fsm_q       <= S_ROUND;
               end
            end
            S_KEY_EXP: begin
               w_q[i_q] <= new_w_d;
               if (i_q == IW'(NW - 1)) begin
                  key_ok_q    <= 1'b1;
                  key_ready_q <= 1'b1;
                  fsm_q       <= S_IDLE;
               end else begin
                  i_q <= i_q + IW'(1);
                  if (kmod_q == 3'(NK - 1)) begin
                     kmod_q <= 3'd0;
                     kdiv_q <= kdiv_q + 4'd1;
                  end else begin
                     kmod_q <= kmod_q + 3'd1;
                  end
               end
            end
            S_ROUND: begin
               st_q <= round_d;
               if (is_last) begin
                  out_valid_q <= 1'b1;
                  fsm_q       <= S_DONE;
               end else begin
                  r_q <= r_q + RW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  key_ready_q <= 1'b1;
                  fsm_q       <= S_IDLE;
               end
            end
            default: fsm_q <= S_IDLE;
         endcase
      end
   end

   assign key_ready = key_ready_q;
   assign key_ok    = key_ok_q;
   assign out_valid = out_valid_q;
   assign data_out  = st_q;
   // key_load masks acceptance in the same cycle it is presented
   assign in_ready  = (fsm_q == S_IDLE) & key_ok_q & ~key_load;

endmodule
